audio_i2s_tx: RTL

I2S serializer that consumes the 12.288 MHz audio master clock produced by the audio PLL and drives the cartridge audio pins. It buffers stereo PCM samples in a small FIFO and derives the serial bit clock and left/right clock from the master clock. It shifts samples out MSB-first in standard I2S format at 48 kHz. It sits directly downstream of the audio PLL; the sample source is already synchronized into the audio clock domain.

---
 rtl/audio_i2s_tx.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: standard I2S serializer (MSB first, one-bit delay, 64 slots per
// frame) fed by a small stereo-pair FIFO. Runs entirely in the clk_audio domain.
// Build option: define AUDIO_I2S_UNDERRUN_HOLD_EN to repeat the last played pair
// on underrun; otherwise an underrun plays silence.
module audio_i2s_tx #(
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned MCLK_DIV   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                             clk_audio,
  input  logic                             reset_n,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [SAMPLE_W-1:0]              s_left,
  input  logic [SAMPLE_W-1:0]              s_right,
  output logic                             audio_sclk,
  output logic                             audio_lrck,
  output logic                             audio_dac,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             underrun
);

  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned DIV_W  = (MCLK_DIV > 2) ? $clog2(MCLK_DIV) : 1;
  localparam int unsigned IDX_W  = (SAMPLE_W > 2) ? $clog2(SAMPLE_W) : 1;
  localparam int unsigned PAIR_W = 2 * SAMPLE_W;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(MCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(MCLK_DIV / 2);
  localparam logic [4:0]       LAST_SLOT = 5'(SAMPLE_W);
  localparam logic [IDX_W-1:0] MSB_IDX   = IDX_W'(SAMPLE_W - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Bit-clock divider and slot counter
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic             sclk_q, sclk_d;
  logic             fe;
  logic             frame_load;

  // Divider wraps once per sclk period; the wrap is the sclk falling edge.
  always_comb begin
    fe         = (div_cnt_q == DIV_LAST);
    div_cnt_d  = fe ? '0 : div_cnt_q + DIV_W'(1);
    sclk_d     = (div_cnt_d >= DIV_HALF);
    bit_cnt_d  = fe ? bit_cnt_q + 6'd1 : bit_cnt_q;
    frame_load = fe && (bit_cnt_q == 6'd63);
  end

  // Divider, slot counter and sclk registers.
  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------------
  logic [PAIR_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  // Readiness comes from the registered level only, so a pop in the same
  // cycle never opens the FIFO combinationally.
  always_comb begin
    fifo_empty = (level_q == '0);
    s_ready    = (level_q < LVL_FULL);
    push       = s_valid && s_ready;
    pop        = frame_load && !fifo_empty;
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d    = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // FIFO storage; contents are only meaningful below the level, so no reset.
  always_ff @(posedge clk_audio) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s_left, s_right};
    end
  end

  // ---------------------------------------------------------------------------
  // Holding registers (pair currently being serialized)
  // ---------------------------------------------------------------------------
  logic [SAMPLE_W-1:0] hold_l_q, hold_l_d;
  logic [SAMPLE_W-1:0] hold_r_q, hold_r_d;
  logic                underrun_q, underrun_d;

  // Frame load: pop the FIFO head, or apply the underrun policy when empty.
  always_comb begin
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    underrun_d = frame_load && fifo_empty;
    if (frame_load) begin
      if (!fifo_empty) begin
        {hold_l_d, hold_r_d} = mem_q[rd_ptr_q];
      end else begin
`ifdef AUDIO_I2S_UNDERRUN_HOLD_EN
        hold_l_d = hold_l_q;
        hold_r_d = hold_r_q;
`else
        hold_l_d = '0;
        hold_r_d = '0;
`endif
      end
    end
  end

  // Holding registers and underrun pulse.
  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      underrun_q <= 1'b0;
    end else begin
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      underrun_q <= underrun_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer
  // ---------------------------------------------------------------------------
  logic                lrck_q, lrck_d;
  logic                dac_q, dac_d;
  logic [4:0]          slot_k;
  logic [IDX_W-1:0]    slot_idx;
  logic [SAMPLE_W-1:0] slot_word;

  // Word select and data are computed for the slot being entered, so they
  // update on the same edge that drops sclk. Slot 0 is always the I2S delay
  // bit, which also covers the edge where the holding registers reload.
  always_comb begin
    slot_k    = bit_cnt_d[4:0];
    slot_word = bit_cnt_d[5] ? hold_r_q : hold_l_q;
    slot_idx  = MSB_IDX - IDX_W'(slot_k - 5'd1);
    lrck_d    = lrck_q;
    dac_d     = dac_q;
    if (fe) begin
      lrck_d = bit_cnt_d[5];
      if ((slot_k != 5'd0) && (slot_k <= LAST_SLOT)) begin
        dac_d = slot_word[slot_idx];
      end else begin
        dac_d = 1'b0;
      end
    end
  end

  // Serial output registers.
  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      lrck_q <= 1'b0;
      dac_q  <= 1'b0;
    end else begin
      lrck_q <= lrck_d;
      dac_q  <= dac_d;
    end
  end

  assign audio_sclk = sclk_q;
  assign audio_lrck = lrck_q;
  assign audio_dac  = dac_q;
  assign fifo_level = level_q;
  assign underrun   = underrun_q;

endmodule
